// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

  localparam int DIV_W_DEFAULT = 8;

endpackage

// File: rtl/sub_borrow.sv
// N-bit ripple-borrow subtractor: diff = a - b - bin, bout is the final borrow.
module sub_borrow #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic [N-1:0] diff,
  output logic         bout
);

  logic [N:0] br;

  always_comb begin
    br    = '0;
    diff  = '0;
    br[0] = bin;
    for (int unsigned i = 0; i < N; i++) begin
      diff[i]  = a[i] ^ b[i] ^ br[i];
      br[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
    end
    bout = br[N];
  end

endmodule

// File: rtl/seq_restoring_div.sv
// Multi-cycle unsigned restoring divider with valid/ready request and result ports.
// Optional DIV_EARLY_OUT_EN: finish in one cycle when dividend < divisor.
module seq_restoring_div
  import div_pkg::*;
#(
  parameter int W     = DIV_W_DEFAULT,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  div_state_t       state;
  logic [W-1:0]     r;
  logic [W-1:0]     q;
  logic [W-1:0]     d;
  logic [CNT_W-1:0] cnt;

  // The partial remainder always stays below D, so its (W+1)th bit is provably
  // zero; only the shifted trial value needs the extra bit.
  logic [W:0]   shifted;
  logic [W-1:0] t;
  logic         t_top_unused;
  logic         borrow;
  logic [W-1:0] r_nxt;
  logic [W-1:0] q_nxt;
  logic         lt;

  assign shifted = {r, q[W-1]};

  sub_borrow #(.N(W + 1)) u_step (
    .a    (shifted),
    .b    ({1'b0, d}),
    .bin  (1'b0),
    .diff ({t_top_unused, t}),
    .bout (borrow)
  );

  always_comb begin
    r_nxt = shifted[W-1:0];
    q_nxt = {q[W-2:0], 1'b0};
    if (!borrow) begin
      r_nxt = t;
      q_nxt = {q[W-2:0], 1'b1};
    end
  end

`ifdef DIV_EARLY_OUT_EN
  logic [W:0] cmp_diff_unused;

  sub_borrow #(.N(W + 1)) u_cmp (
    .a    ({1'b0, dividend}),
    .b    ({1'b0, divisor}),
    .bin  (1'b0),
    .diff (cmp_diff_unused),
    .bout (lt)
  );
`else
  assign lt = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      res_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      r           <= '0;
      q           <= '0;
      d           <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready   <= 1'b0;
            div_by_zero <= 1'b0;
            r           <= '0;
            q           <= dividend;
            d           <= divisor;
            cnt         <= CNT_W'(W);
            if (divisor == '0) begin
              state       <= DONE;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              res_valid   <= 1'b1;
            end else if (lt) begin
              state     <= DONE;
              quotient  <= '0;
              remainder <= dividend;
              res_valid <= 1'b1;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          r   <= r_nxt;
          q   <= q_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state     <= DONE;
            quotient  <= q_nxt;
            remainder <= r_nxt;
            res_valid <= 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_div.sv
// Self-checking bench for seq_restoring_div: vector table, corner sequences, random ops.
module tb_seq_restoring_div;

  localparam int W = 8;
`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam int LAT_FULL = W + 1;
  localparam int LAT_LT   = EARLY ? 1 : W + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  always #5 clk = ~clk;

  seq_restoring_div #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_lat(input int a, input int b);
    if (b == 0) return 1;
    if (EARLY && a < b) return 1;
    return W + 1;
  endfunction

  // One complete transaction; all sampling and driving happens on negedges.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edz, input int elat,
                        input int stall, input bit noise);
    int waitc;
    int lat;
    waitc = 0;
    while (!req_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", 32'(req_ready), 32'd1);
      return;
    end
    req_valid = 1'b1;
    dividend  = a;
    divisor   = b;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    chk("dbz_after_accept", 32'(div_by_zero), 32'(edz));
    while (!res_valid && lat < 40) begin
      chk("busy_req_ready", 32'(req_ready), 32'd0);
      if (noise) begin
        req_valid = 1'($urandom_range(0, 1));
        dividend  = W'($urandom);
        divisor   = W'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    req_valid = 1'b0;
    if (!res_valid) begin
      chk("res_valid_timeout", 32'(res_valid), 32'd1);
      return;
    end
    chk("latency", 32'(lat), 32'(elat));
    chk("quotient", 32'(quotient), 32'(eq));
    chk("remainder", 32'(remainder), 32'(er));
    chk("div_by_zero", 32'(div_by_zero), 32'(edz));
    chk("done_req_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < stall; i++) begin
      req_valid = 1'b1;
      dividend  = W'($urandom);
      divisor   = W'($urandom);
      @(negedge clk);
      chk("stall_res_valid", 32'(res_valid), 32'd1);
      chk("stall_quotient", 32'(quotient), 32'(eq));
      chk("stall_remainder", 32'(remainder), 32'(er));
      chk("stall_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("release_res_valid", 32'(res_valid), 32'd0);
    chk("release_req_ready", 32'(req_ready), 32'd1);
    chk("idle_quotient_hold", 32'(quotient), 32'(eq));
    chk("idle_remainder_hold", 32'(remainder), 32'(er));
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got hang, expected finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    int waitc;

    vecs[0] = '{a: 200, b: 7,   q: 28,  r: 4,  dz: 1'b0, lat: LAT_FULL};
    vecs[1] = '{a: 255, b: 1,   q: 255, r: 0,  dz: 1'b0, lat: LAT_FULL};
    vecs[2] = '{a: 0,   b: 5,   q: 0,   r: 0,  dz: 1'b0, lat: LAT_LT};
    vecs[3] = '{a: 255, b: 255, q: 1,   r: 0,  dz: 1'b0, lat: LAT_FULL};
    vecs[4] = '{a: 13,  b: 0,   q: 255, r: 13, dz: 1'b1, lat: 1};
    vecs[5] = '{a: 5,   b: 9,   q: 0,   r: 5,  dz: 1'b0, lat: LAT_LT};
    vecs[6] = '{a: 9,   b: 2,   q: 4,   r: 1,  dz: 1'b0, lat: LAT_FULL};

    rst       = 1'b1;
    req_valid = 1'b0;
    res_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_res_valid", 32'(res_valid), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_quotient", 32'(quotient), 32'd0);
    chk("reset_remainder", 32'(remainder), 32'd0);
    chk("reset_dbz", 32'(div_by_zero), 32'd0);

    for (int i = 0; i < 7; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].lat, 0, 1'b0);

    // Back-pressure: result held for 5 cycles while new requests are offered.
    run_op(8'd100, 8'd3, 8'd33, 8'd1, 1'b0, LAT_FULL, 5, 1'b0);
    @(negedge clk);
    chk("bp_not_accepted_res_valid", 32'(res_valid), 32'd0);
    chk("bp_not_accepted_req_ready", 32'(req_ready), 32'd1);

    // Reset during the 4th CALC cycle of 200 / 7.
    req_valid = 1'b1;
    dividend  = 8'd200;
    divisor   = 8'd7;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_abort_busy", 32'(req_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_quotient", 32'(quotient), 32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    chk("abort_res_valid", 32'(res_valid), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    chk("abort_dbz", 32'(div_by_zero), 32'd0);
    repeat (W + 2) begin
      @(negedge clk);
      chk("abort_no_result", 32'(res_valid), 32'd0);
    end
    run_op(8'd9, 8'd2, 8'd4, 8'd1, 1'b0, LAT_FULL, 0, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      a = W'($urandom);
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 4));
        2:       a = W'($urandom_range(0, 15));
        default: b = W'($urandom);
      endcase
      if (n % 8 != 0 && b == '0 && $urandom_range(0, 1) == 0) b = 8'd1;
      run_op(a, b,
             (b == '0) ? '1 : W'(int'(a) / int'(b)),
             (b == '0) ? a  : W'(int'(a) % int'(b)),
             (b == '0), model_lat(int'(a), int'(b)),
             int'($urandom_range(0, 3)), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
